serial_alu_seq: RTL and testbench
=================================

# serial_alu_seq

Bit-serial ALU sequencer that issues operations one bit per cycle to a 1-bit ALU slice and assembles the WIDTH-bit result. It accepts a whole-word request (opcode plus two operands) and walks bits LSB-first, feeding each cycle's carry back as the next carry-in. It returns the word, the final carry and a done pulse. It sits between the datapath register file and a single shared 1-bit slice, trading latency for area.

## Interface
- WIDTH, 32, operand/result width (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- select  in  3  opcode: 000 MOV, 001 NOT, 010 ADD, 011 SUB, 100 OR, 101 AND, 110/111 reserved
- r2  in  WIDTH  operand A
- r3  in  WIDTH  operand B
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  assembled result; held until the next accepted start
- c_out  out  1  final carry
- zero  out  1  result==0 flag (see Configuration)
- ovf  out  1  signed overflow flag (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE to RUN on start=1 at the clock edge:
  - latch select, r2 and r3 into shift registers
  - bit counter = 0
  - carry = 1 for SUB, 0 otherwise
  - result is not cleared until the first RUN edge
- RUN, each edge: slice evaluates bit 0 of the shifted operands with the current carry.
  - Slice output is shifted into result at the MSB (result shifts right).
  - Operands shift right.
  - Carry is updated.
  - Counter increments.
- Slice function:
  - MOV = a
  - NOT = ~a
  - ADD = a^b^c
  - SUB = a^~b^c
  - OR = a|b
  - AND = a&b
- Carry rules:
  - ADD/SUB: carry = full-adder carry-out (B inverted for SUB).
  - All other opcodes pass carry through unchanged.
- Reserved opcodes: slice output 0 and carry passes through. The result is all-zero and the sequence completes normally.
- When the counter reaches WIDTH-1, RUN goes to DONE on that edge. c_out is registered from the final carry.
- DONE: done=1 for exactly one cycle, then the next edge goes to IDLE.
- start while busy is ignored, with no queuing.
- Arithmetic is modulo 2^WIDTH. SUB c_out=1 means no borrow (r2 ≥ r3 unsigned).

## Timing
- Accepting edge = E0. Bits are processed on edges E1..E_WIDTH.
- done is high between E_WIDTH and E_WIDTH+1.
- Latency from accepting edge to done: WIDTH cycles. Throughput: one op per WIDTH+2 cycles.
- busy rises the cycle after E0 and falls after E_WIDTH+1.
- Earliest next accepted start is at E_WIDTH+2 (start held high in IDLE is taken immediately).
- Reset values: state IDLE, busy 0, done 0, result 0, c_out 0, zero 0, ovf 0, counter 0.
- Reset asserted in RUN or DONE aborts the operation immediately. No done pulse is produced, and partial result bits are discarded (result = 0).
- result, c_out, zero and ovf change only on RUN edges or at reset. They are stable whenever done=1 and through the following IDLE.

## Configuration
- SERIAL_ALU_FLAGS_EN defined:
  - zero is registered at the RUN-to-DONE edge as (final result == 0).
  - ovf is registered at the same edge as (carry into MSB XOR carry out of MSB) for ADD/SUB, and 0 for other opcodes.
- Not defined: zero and ovf ports remain and are tied 0. No flag logic is synthesized.

## Structure
- Package serial_alu_pkg holds:
  - opcode localparams (OP_MOV..OP_AND, OP_RSVD6/7)
  - state encoding (ST_IDLE, ST_RUN, ST_DONE)
  - counter width derived as $clog2(WIDTH)
- One sub-module, serial_alu_slice: purely combinational 1-bit function plus carry-out, driven by select, a, b and cin.
- The top holds the FSM, counter, operand/result shift registers, carry register and flags.

## Test plan (WIDTH=8)
- ADD 0x7F+0x01 -> result 0x80, c_out 0, done exactly 8 cycles after the accepting edge; with the macro, ovf 1 and zero 0.
- SUB 0x07-0x05 -> 0x02, c_out 1. SUB 0x05-0x07 -> 0xFE, c_out 0. SUB 0x80-0x01 -> 0x7F, ovf 1 (macro).
- NOT 0xA5 -> 0x5A; MOV 0x3C -> 0x3C; OR 0xF0|0x0F -> 0xFF; AND 0xF0&0x0F -> 0x00, zero 1 (macro); c_out 0 for all four.
- start re-pulsed at cycles 2 and 5 of a running ADD with different operands -> ignored; the original result is returned; busy stays high; a single done pulse.
- rst asserted mid-RUN at bit 4 -> busy/done/result/c_out go 0 immediately; no done pulse; the next start runs a full clean 8-bit op.
- Reserved select 110 with r2=0xFF, r3=0xFF -> result 0x00, c_out 0, normal done timing.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - opcode encodings for the 3-bit select field (MOV, NOT, ADD, SUB, OR, AND, two reserved)
//   - sequencer state encoding (IDLE, RUN, DONE)
//   - counterWidth(): bit counter width for a given operand width
package serial_alu_pkg;

    localparam logic [2:0] OP_MOV   = 3'b000;
    localparam logic [2:0] OP_NOT   = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_RSVD6 = 3'b110;
    localparam logic [2:0] OP_RSVD7 = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
    // A floor of one bit keeps the vector legal for degenerate widths.
    function automatic int counterWidth(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// serial_alu_slice
// Purely combinational 1-bit ALU slice shared by the serial sequencer.
// Ports:
//   i_select  opcode (see serial_alu_pkg)
//   i_a, i_b  operand bits
//   i_cin     carry in
//   o_y       result bit
//   o_cout    carry out (full-adder carry for ADD/SUB, i_cin passed through otherwise)
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic [2:0] i_select,
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    output logic       o_y,
    output logic       o_cout
);

    logic w_bEff;

    // Subtraction is a + ~b + 1; the +1 comes from the carry being seeded
    // with 1 by the sequencer, so the slice only has to invert b here.
    assign w_bEff = (i_select == OP_SUB) ? ~i_b : i_b;

    // Non-arithmetic opcodes leave the carry untouched so that it simply
    // rides through the sequence; reserved opcodes produce a zero bit.
    always_comb begin
        o_y    = 1'b0;
        o_cout = i_cin;
        case (i_select)
            OP_MOV: o_y = i_a;
            OP_NOT: o_y = ~i_a;
            OP_ADD, OP_SUB: begin
                o_y    = i_a ^ w_bEff ^ i_cin;
                o_cout = (i_a & w_bEff) | (i_cin & (i_a ^ w_bEff));
            end
            OP_OR:  o_y = i_a | i_b;
            OP_AND: o_y = i_a & i_b;
            default: o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq
// Bit-serial ALU sequencer: accepts a whole-word request, walks the operands
// LSB-first through one shared 1-bit slice (one bit per clock) and assembles
// the WIDTH-bit result, the final carry and a one-cycle done pulse.
// Optional feature macro: SERIAL_ALU_FLAGS_EN enables the zero/ovf flag
// registers; without it both flag ports are tied to 0.
// Ports:
//   i_clk, i_rst       rising-edge clock, asynchronous active-high reset
//   i_start            request strobe, only honoured in IDLE
//   i_select           opcode
//   i_r2, i_r3         operands A and B
//   o_busy             high in RUN and DONE
//   o_done             one-cycle completion pulse
//   o_result           assembled result, held until the next accepted start
//   o_c_out            final carry (for SUB: 1 means no borrow)
//   o_zero, o_ovf      result-is-zero and signed-overflow flags
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_select,
    input  logic [WIDTH-1:0] i_r2,
    input  logic [WIDTH-1:0] i_r3,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c_out,
    output logic             o_zero,
    output logic             o_ovf
);

    localparam int             CW       = counterWidth(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_cOut;

    logic             w_sliceY;
    logic             w_sliceCout;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_nextResult;

    serial_alu_slice u_slice (
        .i_select (r_op),
        .i_a      (r_opA[0]),
        .i_b      (r_opB[0]),
        .i_cin    (r_carry),
        .o_y      (w_sliceY),
        .o_cout   (w_sliceCout)
    );

    // Each slice bit enters at the MSB so that after WIDTH shifts the first
    // (least significant) bit has walked down to position 0.
    assign w_nextResult = {w_sliceY, r_result[WIDTH-1:1]};
    assign w_lastBit    = (r_state == ST_RUN) && (r_count == LAST_BIT);

    // Main sequencer. In IDLE a start latches the request and seeds the carry
    // (1 for SUB to form the two's complement). The previous result is left
    // visible until the first RUN edge overwrites it. On the last bit the final
    // carry is captured and the FSM moves to DONE for exactly one cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_op     <= OP_MOV;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cOut   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_op    <= i_select;
                        r_opA   <= i_r2;
                        r_opB   <= i_r3;
                        r_count <= '0;
                        r_carry <= (i_select == OP_SUB);
                    end
                end
                ST_RUN: begin
                    r_result <= w_nextResult;
                    r_opA    <= r_opA >> 1;
                    r_opB    <= r_opB >> 1;
                    r_carry  <= w_sliceCout;
                    r_count  <= r_count + CW'(1);
                    if (w_lastBit) begin
                        r_state <= ST_DONE;
                        r_cOut  <= w_sliceCout;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic r_zero;
    logic r_ovf;

    // Flags are captured together with the final carry. On the last bit the
    // carry register holds the carry into the MSB and the slice produces the
    // carry out of it; their XOR is the signed overflow for ADD/SUB.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_lastBit) begin
            r_zero <= (w_nextResult == '0);
            r_ovf  <= ((r_op == OP_ADD) || (r_op == OP_SUB)) && (r_carry ^ w_sliceCout);
        end
    end

    assign o_zero = r_zero;
    assign o_ovf  = r_ovf;
`else
    assign o_zero = 1'b0;
    assign o_ovf  = 1'b0;
`endif

    assign o_busy   = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign o_done   = (r_state == ST_DONE);
    assign o_result = r_result;
    assign o_c_out  = r_cOut;

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq
// Self-checking bench for serial_alu_seq at WIDTH=8. Expected values come from
// a word-level arithmetic model of each opcode. Honours SERIAL_ALU_FLAGS_EN
// for the zero/ovf expectations.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   select;
    logic [W-1:0] r2;
    logic [W-1:0] r3;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cOut;
    logic         zero;
    logic         ovf;

    int errorCount = 0;
    int checkCount = 0;

    serial_alu_seq #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_select (select),
        .i_r2     (r2),
        .i_r3     (r3),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result),
        .o_c_out  (cOut),
        .o_zero   (zero),
        .o_ovf    (ovf)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Word-level reference: plain modular arithmetic on whole operands.
    task automatic modelOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic c, output logic z, output logic v);
        int unsigned s;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'd0: res = a;
            3'd1: res = ~a;
            3'd2: begin
                s   = int'(a) + int'(b);
                res = W'(s % 256);
                c   = (s > 255);
                v   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            3'd3: begin
                s   = (int'(a) + 256 - int'(b)) % 256;
                res = W'(s);
                c   = (a >= b);
                v   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            3'd4: res = a | b;
            3'd5: res = a & b;
            default: res = '0;
        endcase
        z = (res == '0);
`ifndef SERIAL_ALU_FLAGS_EN
        z = 1'b0;
        v = 1'b0;
`endif
    endtask

    // Issue one operation, measure done latency and check all outputs.
    task automatic applyStimulus(input string tag, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] expRes;
        logic         expC, expZ, expV;
        int           cycles;
        bit           seen;
        modelOp(op, a, b, expRes, expC, expZ, expV);
        @(negedge clk);
        start  = 1'b1;
        select = op;
        r2     = a;
        r3     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({tag, ".busyAfterE0"}, 32'(busy), 32'd1);
        cycles = 0;
        seen   = 0;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) seen = 1;
        end
        checkOutput({tag, ".doneLatency"}, 32'(cycles), 32'(W));
        checkOutput({tag, ".result"}, 32'(result), 32'(expRes));
        checkOutput({tag, ".cOut"}, 32'(cOut), 32'(expC));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expZ));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expV));
        @(posedge clk);
        #1;
        checkOutput({tag, ".doneOneCycle"}, 32'(done), 32'd0);
        checkOutput({tag, ".busyFall"}, 32'(busy), 32'd0);
        checkOutput({tag, ".resultHeld"}, 32'(result), 32'(expRes));
    endtask

    initial begin
        logic [W-1:0] expRes;
        logic         expC, expZ, expV;
        int           doneSeen;

        rst    = 1'b1;
        start  = 1'b0;
        select = 3'd0;
        r2     = '0;
        r3     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.result", 32'(result), 32'd0);
        checkOutput("reset.cOut", 32'(cOut), 32'd0);
        checkOutput("reset.zero", 32'(zero), 32'd0);
        checkOutput("reset.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("add7F01", 3'd2, 8'h7F, 8'h01);
        applyStimulus("sub0705", 3'd3, 8'h07, 8'h05);
        applyStimulus("sub0507", 3'd3, 8'h05, 8'h07);
        applyStimulus("sub8001", 3'd3, 8'h80, 8'h01);
        applyStimulus("notA5", 3'd1, 8'hA5, 8'h00);
        applyStimulus("mov3C", 3'd0, 8'h3C, 8'hC3);
        applyStimulus("orF00F", 3'd4, 8'hF0, 8'h0F);
        applyStimulus("andF00F", 3'd5, 8'hF0, 8'h0F);
        applyStimulus("rsvd6", 3'd6, 8'hFF, 8'hFF);
        applyStimulus("rsvd7", 3'd7, 8'hFF, 8'hFF);

        // start re-pulsed mid-run with other operands must be ignored
        modelOp(3'd2, 8'h12, 8'h34, expRes, expC, expZ, expV);
        @(negedge clk);
        start  = 1'b1;
        select = 3'd2;
        r2     = 8'h12;
        r3     = 8'h34;
        @(posedge clk);
        #1;
        start    = 1'b0;
        doneSeen = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k == 2 || k == 5) begin
                start  = 1'b1;
                select = 3'd3;
                r2     = 8'hEE;
                r3     = 8'h99;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) doneSeen++;
            checkOutput($sformatf("repulse.busy%0d", k), 32'(busy), (k <= W) ? 32'd1 : 32'd0);
            if (k == W) begin
                checkOutput("repulse.result", 32'(result), 32'(expRes));
                checkOutput("repulse.cOut", 32'(cOut), 32'(expC));
            end
        end
        checkOutput("repulse.doneCount", 32'(doneSeen), 32'd1);

        // reset in the middle of a run aborts it without a done pulse
        @(negedge clk);
        start  = 1'b1;
        select = 3'd2;
        r2     = 8'hFF;
        r3     = 8'h01;
        @(posedge clk);
        #1;
        start    = 1'b0;
        doneSeen = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        rst = 1'b1;
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.result", 32'(result), 32'd0);
        checkOutput("abort.cOut", 32'(cOut), 32'd0);
        @(posedge clk);
        #1;
        if (done) doneSeen++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("abort.noDone", 32'(doneSeen), 32'd0);
        applyStimulus("afterAbort", 3'd2, 8'hC8, 8'h64);

        // randomized operations against the word-level model
        for (int n = 0; n < 40; n++) begin
            applyStimulus($sformatf("rand%0d", n), 3'($urandom_range(0, 7)),
                          W'($urandom), W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
